fc_layer_ctrl: RTL and testbench

Sequencer for the fully connected layer of the digit-recognition pipeline. On `start` it computes the output neurons one after another. For each neuron it walks the feature buffer and the FC weight memory, drives the external MAC's clear/accumulate strobes aligned to memory read latency, and writes each finished accumulator value to the result buffer. It also tracks the running argmax, so the predicted digit is available when the layer completes.

---
 rtl/fc_layer_ctrl.sv | 154 +++++++++++++++
 tb/tb_fc_layer_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_ctrl.sv
// Fully connected layer sequencer: walks features/weights per output neuron, drives the
// external MAC strobes aligned to memory read latency, writes results and tracks the argmax.
module fc_layer_ctrl #(
   parameter int N_IN    = 64,
   parameter int N_OUT   = 10,
   parameter int RD_LAT  = 1,
   parameter int ACC_W   = 24,
   parameter int FEAT_AW = 6,
   parameter int W_AW    = 10
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic                    mem_rd_en,
   output logic [FEAT_AW-1:0]      feat_addr,
   output logic [W_AW-1:0]         w_addr,
   output logic                    mac_clr,
   output logic                    mac_en,
   input  logic signed [ACC_W-1:0] acc_in,
   output logic                    res_we,
   output logic [3:0]              res_addr,
   output logic [ACC_W-1:0]        res_data,
   output logic [3:0]              pred,
   output logic                    pred_valid
);

   typedef enum logic [2:0] {StIdle, StRead, StDrain, StWrite, StDone} state_e;

   localparam logic [FEAT_AW-1:0] LastI     = FEAT_AW'(N_IN - 1);
   localparam logic [3:0]         LastN     = 4'(N_OUT - 1);
   localparam logic [2:0]         LastDrain = 3'(RD_LAT);

   state_e                  state_q, state_d;
   logic [FEAT_AW-1:0]      i_q, i_d;
   logic [W_AW-1:0]         w_cnt_q, w_cnt_d;
   logic [3:0]              n_q, n_d;
   logic [2:0]              drain_q, drain_d;
   logic signed [ACC_W-1:0] max_val_q, max_val_d;
   logic [3:0]              pred_q, pred_d;
   logic                    pred_valid_q, pred_valid_d;
   logic [RD_LAT-1:0]       en_pipe_q, en_pipe_d;
   logic [RD_LAT-1:0]       clr_pipe_q, clr_pipe_d;
   logic                    rd_en;

   assign rd_en = (state_q == StRead);

   always_comb begin
      state_d      = state_q;
      i_d          = i_q;
      w_cnt_d      = w_cnt_q;
      n_d          = n_q;
      drain_d      = drain_q;
      max_val_d    = max_val_q;
      pred_d       = pred_q;
      pred_valid_d = pred_valid_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               n_d          = 4'd0;
               i_d          = '0;
               w_cnt_d      = '0;
               pred_valid_d = 1'b0;
               state_d      = StRead;
            end
         end
         StRead: begin
            // Weight address is a free-running counter, so no n*N_IN multiply is needed.
            w_cnt_d = w_cnt_q + W_AW'(1);
            if (i_q == LastI) begin
               i_d     = '0;
               drain_d = 3'd0;
               state_d = StDrain;
            end else begin
               i_d = i_q + FEAT_AW'(1);
            end
         end
         StDrain: begin
            if (drain_q == LastDrain) begin
               state_d = StWrite;
            end else begin
               drain_d = drain_q + 3'd1;
            end
         end
         StWrite: begin
            // Strict compare keeps the lower index on ties; neuron 0 always loads.
            if ((n_q == 4'd0) || (acc_in > max_val_q)) begin
               max_val_d = acc_in;
               pred_d    = n_q;
            end
            if (n_q == LastN) begin
               state_d = StDone;
            end else begin
               n_d     = n_q + 4'd1;
               state_d = StRead;
            end
         end
         StDone: begin
            pred_valid_d = 1'b1;
            state_d      = StIdle;
         end
         default: state_d = StIdle;
      endcase

      en_pipe_d[0]  = rd_en;
      clr_pipe_d[0] = rd_en & (i_q == '0);
      for (int k = 1; k < RD_LAT; k++) begin
         en_pipe_d[k]  = en_pipe_q[k-1];
         clr_pipe_d[k] = clr_pipe_q[k-1];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         i_q          <= '0;
         w_cnt_q      <= '0;
         n_q          <= 4'd0;
         drain_q      <= 3'd0;
         max_val_q    <= '0;
         pred_q       <= 4'd0;
         pred_valid_q <= 1'b0;
         en_pipe_q    <= '0;
         clr_pipe_q   <= '0;
      end else begin
         state_q      <= state_d;
         i_q          <= i_d;
         w_cnt_q      <= w_cnt_d;
         n_q          <= n_d;
         drain_q      <= drain_d;
         max_val_q    <= max_val_d;
         pred_q       <= pred_d;
         pred_valid_q <= pred_valid_d;
         en_pipe_q    <= en_pipe_d;
         clr_pipe_q   <= clr_pipe_d;
      end
   end

   assign busy       = (state_q != StIdle);
   assign done       = (state_q == StDone);
   assign mem_rd_en  = rd_en;
   assign feat_addr  = i_q;
   assign w_addr     = w_cnt_q;
   assign mac_en     = en_pipe_q[RD_LAT-1];
   assign mac_clr    = clr_pipe_q[RD_LAT-1];
   assign res_we     = (state_q == StWrite);
   assign res_addr   = n_q;
   assign res_data   = res_we ? acc_in : '0;
   assign pred       = pred_q;
   assign pred_valid = pred_valid_q;

endmodule

// File: tb/tb_fc_layer_ctrl.sv
// Bench for fc_layer_ctrl: three configurations, a MAC model producing chosen per-neuron
// results, directed runs plus mid-layer start and asynchronous reset sequences.
module tb_fc_layer_ctrl;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic              start_s [3];
   logic              busy_s  [3];
   logic              done_s  [3];
   logic              rd_s    [3];
   logic [5:0]        feat_s  [3];
   logic [9:0]        w_s     [3];
   logic              en_s    [3];
   logic              clr_s   [3];
   logic signed [23:0] acc_m  [3];
   logic              we_s    [3];
   logic [3:0]        raddr_s [3];
   logic [23:0]       rdata_s [3];
   logic [3:0]        pred_s  [3];
   logic              pv_s    [3];

   int tgt [3][10];
   int nin [3];
   int clr_cnt [3];

   int pass_cnt = 0;
   int total_cnt = 0;
   int sel = 0;

   fc_layer_ctrl u0 (
      .clk(clk), .reset(reset), .start(start_s[0]), .busy(busy_s[0]), .done(done_s[0]),
      .mem_rd_en(rd_s[0]), .feat_addr(feat_s[0]), .w_addr(w_s[0]), .mac_clr(clr_s[0]),
      .mac_en(en_s[0]), .acc_in(acc_m[0]), .res_we(we_s[0]), .res_addr(raddr_s[0]),
      .res_data(rdata_s[0]), .pred(pred_s[0]), .pred_valid(pv_s[0])
   );

   fc_layer_ctrl #(.N_IN(4), .N_OUT(2), .RD_LAT(3)) u1 (
      .clk(clk), .reset(reset), .start(start_s[1]), .busy(busy_s[1]), .done(done_s[1]),
      .mem_rd_en(rd_s[1]), .feat_addr(feat_s[1]), .w_addr(w_s[1]), .mac_clr(clr_s[1]),
      .mac_en(en_s[1]), .acc_in(acc_m[1]), .res_we(we_s[1]), .res_addr(raddr_s[1]),
      .res_data(rdata_s[1]), .pred(pred_s[1]), .pred_valid(pv_s[1])
   );

   fc_layer_ctrl #(.N_IN(1), .N_OUT(1), .RD_LAT(1)) u2 (
      .clk(clk), .reset(reset), .start(start_s[2]), .busy(busy_s[2]), .done(done_s[2]),
      .mem_rd_en(rd_s[2]), .feat_addr(feat_s[2]), .w_addr(w_s[2]), .mac_clr(clr_s[2]),
      .mac_en(en_s[2]), .acc_in(acc_m[2]), .res_we(we_s[2]), .res_addr(raddr_s[2]),
      .res_data(rdata_s[2]), .pred(pred_s[2]), .pred_valid(pv_s[2])
   );

   // MAC model: the clear loads target-(N_IN-1) so N_IN-1 further accumulates land on target.
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (start_s[k] && !busy_s[k]) begin
            clr_cnt[k] <= 0;
         end else if (en_s[k]) begin
            if (clr_s[k]) begin
               acc_m[k]   <= 24'(tgt[k][clr_cnt[k] % 10] - (nin[k] - 1));
               clr_cnt[k] <= clr_cnt[k] + 1;
            end else begin
               acc_m[k] <= acc_m[k] + 24'sd1;
            end
         end
      end
   end

   task automatic chk(input string name, input longint act, input longint exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic longint all_outs(input int k);
      return longint'({busy_s[k], done_s[k], rd_s[k], feat_s[k], w_s[k], en_s[k], clr_s[k],
                       we_s[k], raddr_s[k], rdata_s[k], pred_s[k], pv_s[k]});
   endfunction

   typedef struct {
      int inst;
      int n_in;
      int n_out;
      int rd_lat;
      int mode;
      int glitch_at;
      int exp_pred;
   } run_t;

   task automatic run_layer(input run_t r);
      int  per      = r.n_in + r.rd_lat + 2;
      int  exp_done = 1 + r.n_out * per;
      int  rd_n = 0, en_n = 0, clr_n = 0, we_n = 0, done_cyc = -1;
      int  align_err = 0, addr_err = 0, busy_err = 0, misc_err = 0;
      bit  hist [0:1023];
      bit  exp_en, exp_clr;
      int  k = r.inst;
      sel = k;
      @(negedge clk);
      start_s[k] = 1'b1;
      @(negedge clk);
      start_s[k] = 1'b0;
      for (int c = 1; c <= exp_done + 20; c++) begin
         if (c > 1) @(negedge clk);
         hist[c] = rd_s[k];
         if (c == 1) chk("pred_valid_cleared", longint'(pv_s[k]), 0);
         if (rd_s[k]) begin
            if (int'(w_s[k]) != rd_n || int'(feat_s[k]) != rd_n % r.n_in) addr_err++;
            rd_n++;
         end
         exp_en  = (c > r.rd_lat) ? hist[c - r.rd_lat] : 1'b0;
         exp_clr = exp_en && ((c - 1 - r.rd_lat) % per == 0);
         if (en_s[k] != exp_en || clr_s[k] != exp_clr) align_err++;
         if (en_s[k]) en_n++;
         if (clr_s[k]) clr_n++;
         if (busy_s[k] != (c <= exp_done)) busy_err++;
         if (we_s[k]) begin
            chk("res_we_cycle", c, (we_n + 1) * per);
            chk("res_addr", longint'(raddr_s[k]), we_n);
            chk("res_data", longint'($signed(rdata_s[k])), tgt[k][we_n % 10]);
            if (en_s[k]) misc_err++;
            we_n++;
         end
         if (done_s[k]) begin
            if (done_cyc < 0) done_cyc = c;
            else misc_err++;
         end
         if (c == exp_done + 1) begin
            chk("pred_valid", longint'(pv_s[k]), 1);
            chk("pred", longint'(pred_s[k]), r.exp_pred);
         end
         start_s[k] = (c == r.glitch_at);
      end
      start_s[k] = 1'b0;
      chk("rd_count", rd_n, r.n_in * r.n_out);
      chk("mac_en_count", en_n, r.n_in * r.n_out);
      chk("mac_clr_count", clr_n, r.n_out);
      chk("res_we_count", we_n, r.n_out);
      chk("done_cycle", done_cyc, exp_done);
      chk("addr_errors", addr_err, 0);
      chk("strobe_align_errors", align_err, 0);
      chk("busy_errors", busy_err, 0);
      chk("misc_errors", misc_err, 0);
   endtask

   task automatic reset_mid_run();
      int strobe_err = 0;
      sel = 0;
      @(negedge clk);
      start_s[0] = 1'b1;
      @(negedge clk);
      start_s[0] = 1'b0;
      for (int c = 2; c <= 100; c++) @(negedge clk);
      chk("busy_before_reset", longint'(busy_s[0]), 1);
      chk("rd_en_before_reset", longint'(rd_s[0]), 1);
      #2 reset = 1'b1;
      #1 chk("async_reset_outputs", all_outs(0), 0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (rd_s[0] || en_s[0] || clr_s[0] || we_s[0] || busy_s[0] || done_s[0]) strobe_err++;
      end
      chk("idle_after_reset", strobe_err, 0);
   endtask

   run_t runs [5];

   initial begin
      for (int k = 0; k < 3; k++) begin
         start_s[k] = 1'b0;
         clr_cnt[k] = 0;
      end
      nin = '{64, 4, 1};
      tgt[0] = '{-5, 7, 7, -100, 3, 0, 6, 7, -1, 2};
      tgt[1] = '{100, -100, 0, 0, 0, 0, 0, 0, 0, 0};
      tgt[2] = '{42, 0, 0, 0, 0, 0, 0, 0, 0, 0};

      //          inst n_in n_out lat mode glitch pred
      runs[0] = '{0,   64,  10,   1,  0,   50,    1};
      runs[1] = '{0,   64,  10,   1,  1,   0,     1};
      runs[2] = '{1,   4,   2,    3,  0,   0,     0};
      runs[3] = '{2,   1,   1,    1,  0,   0,     0};
      runs[4] = '{0,   64,  10,   1,  0,   0,     1};

      repeat (2) @(negedge clk);
      chk("reset_state_u0", all_outs(0), 0);
      chk("reset_state_u1", all_outs(1), 0);
      reset = 1'b0;
      @(negedge clk);
      chk("idle_after_release", all_outs(0), 0);

      for (int r = 0; r < 4; r++) begin
         if (runs[r].mode == 1) tgt[0] = '{-9, -3, -3, -20, -4, -7, -3, -100, -50, -8};
         else tgt[0] = '{-5, 7, 7, -100, 3, 0, 6, 7, -1, 2};
         run_layer(runs[r]);
      end

      repeat (5) @(negedge clk);
      chk("pred_hold_u2", longint'({pv_s[2], pred_s[2]}), 16);

      reset_mid_run();
      tgt[0] = '{-5, 7, 7, -100, 3, 0, 6, 7, -1, 2};
      run_layer(runs[4]);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
